// File: rtl/g_share_pkg.sv
// Shared types and constants for the gshare branch predictor.
// Holds the 2-bit saturating counter type and its four named states.
package g_share_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t SNT = 2'b00;
    localparam cnt_t WNT = 2'b01;
    localparam cnt_t WT  = 2'b10;
    localparam cnt_t ST  = 2'b11;

    // The MSB of a counter is its taken/not-taken vote.
    function automatic logic cnt_taken(input cnt_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/g_share_if.sv
// Predict/train request bundle between a pipeline front end and the gshare predictor.
interface g_share_if;

    logic [31:0] predictPc;
    logic [31:0] updatePc;
    logic        predict;
    logic        update;
    logic        reality;
    logic        prediction;

    modport master (
        output predictPc, updatePc, predict, update, reality,
        input  prediction
    );

    modport slave (
        input  predictPc, updatePc, predict, update, reality,
        output prediction
    );

endinterface

// File: rtl/g_share_sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import g_share_pkg::*;
(
    input  cnt_t state,
    input  logic taken,
    output cnt_t next_state
);

    always_comb begin
        next_state = state;
        if (taken) begin
            if (state != ST) next_state = state + 2'd1;
        end else begin
            if (state != SNT) next_state = state - 2'd1;
        end
    end

endmodule

// File: rtl/g_share.sv
// gshare predictor: PC xor global history indexes a flop-based table of 2-bit counters.
// Define GSHARE_BYPASS_EN to forward a same-cycle update into a same-index prediction.
module g_share
    import g_share_pkg::*;
#(
    parameter int GHR_BITS = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    g_share_if.slave bus
);

    localparam int DEPTH = 1 << GHR_BITS;

    logic [GHR_BITS-1:0] ghr_reg;
    cnt_t                pht_reg [DEPTH];
    logic                prediction_reg;

    logic [GHR_BITS-1:0] pred_idx;
    logic [GHR_BITS-1:0] upd_idx;
    cnt_t                upd_next;
    logic                pred_next;

    assign pred_idx = bus.predictPc[GHR_BITS+1:2] ^ ghr_reg;
    assign upd_idx  = bus.updatePc[GHR_BITS+1:2]  ^ ghr_reg;

    // Only the index field of each PC participates in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.predictPc[31:GHR_BITS+2], bus.predictPc[1:0],
                              bus.updatePc[31:GHR_BITS+2],  bus.updatePc[1:0]};

    sat_counter2 u_sat (
        .state      (pht_reg[upd_idx]),
        .taken      (bus.reality),
        .next_state (upd_next)
    );

    always_comb begin
        pred_next = cnt_taken(pht_reg[pred_idx]);
`ifdef GSHARE_BYPASS_EN
        if (bus.update && (pred_idx == upd_idx)) pred_next = cnt_taken(upd_next);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_reg        <= '0;
            prediction_reg <= 1'b0;
        end else begin
            if (bus.predict) prediction_reg <= pred_next;
            if (bus.update)  ghr_reg        <= {ghr_reg[GHR_BITS-2:0], bus.reality};
        end
    end

    // Flops rather than RAM so an asynchronous reset restores every entry to weak-NT at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pht_reg[i] <= WNT;
        end else if (bus.update) begin
            pht_reg[upd_idx] <= upd_next;
        end
    end

    assign bus.prediction = prediction_reg;

endmodule

// File: tb/tb_g_share.sv
// Directed self-checking bench for g_share (GHR_BITS=10); honours GSHARE_BYPASS_EN.
module tb_g_share;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    g_share_if bus ();

    g_share #(.GHR_BITS(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given request; returns 1 time unit after the edge.
    task automatic step(input logic p, input logic [31:0] ppc,
                        input logic u, input logic [31:0] upc, input logic r);
        @(negedge clk);
        bus.predict   = p;
        bus.predictPc = ppc;
        bus.update    = u;
        bus.updatePc  = upc;
        bus.reality   = r;
        @(posedge clk);
        #1;
        $display("step p=%0b ppc=%08h u=%0b upc=%08h r=%0b -> prediction=%0b ghr=%03h",
                 p, ppc, u, upc, r, bus.prediction, dut.ghr_reg);
    endtask

    logic exp_bypass;

    initial begin
`ifdef GSHARE_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        bus.predict = 0; bus.predictPc = 0; bus.update = 0; bus.updatePc = 0; bus.reality = 0;
        #12;
        chk("rst_pred", 32'(bus.prediction), 0);
        chk("rst_ghr", 32'(dut.ghr_reg), 0);
        chk("rst_pht0", 32'(dut.pht_reg[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Weak-NT initial counter predicts not taken
        step(1, 32'h0, 0, 32'h0, 0);
        chk("init_pred", 32'(bus.prediction), 0);

        // Not-taken training at index 0
        step(0, 32'h0, 1, 32'h0, 0);
        chk("nt_pht0", 32'(dut.pht_reg[0]), 0);
        chk("nt_ghr", 32'(dut.ghr_reg), 0);
        step(1, 32'h0, 0, 32'h0, 0);
        chk("nt_pred", 32'(bus.prediction), 0);
        step(0, 32'h0, 1, 32'h0, 0);
        chk("floor_pht0", 32'(dut.pht_reg[0]), 0);

        // Three taken updates walk indices 0,1,3
        step(0, 32'h0, 1, 32'h0, 1);
        step(0, 32'h0, 1, 32'h0, 1);
        step(0, 32'h0, 1, 32'h0, 1);
        chk("t3_ghr", 32'(dut.ghr_reg), 32'h7);
        chk("t3_pht0", 32'(dut.pht_reg[0]), 1);
        chk("t3_pht1", 32'(dut.pht_reg[1]), 2);
        chk("t3_pht3", 32'(dut.pht_reg[3]), 2);
        step(1, 32'h1C, 0, 32'h0, 0);
        chk("t3_pred_1c", 32'(bus.prediction), 0);
        step(1, 32'h8, 0, 32'h0, 0);
        chk("t3_pred_08", 32'(bus.prediction), 0);
        step(1, 32'h10, 0, 32'h0, 0);
        chk("t3_pred_idx3", 32'(bus.prediction), 1);
        step(1, 32'h0, 0, 32'h0, 0);
        chk("t3_pred_idx7", 32'(bus.prediction), 0);
        // Field [11:2]=6 -> index 1; bits [1:0] and above 11 ignored
        step(1, 32'hABCD_E01B, 0, 32'h0, 0);
        chk("t3_pred_hibits", 32'(bus.prediction), 1);
        step(0, 32'h0, 0, 32'h0, 0);
        step(0, 32'h0, 0, 32'h0, 0);
        chk("hold_pred", 32'(bus.prediction), 1);
        chk("hold_ghr", 32'(dut.ghr_reg), 32'h7);

        // Fill GHR with ones so taken updates keep it at 0x3FF
        for (int i = 0; i < 7; i++) step(0, 32'h0, 1, 32'h0, 1);
        chk("fill_ghr", 32'(dut.ghr_reg), 32'h3FF);
        for (int i = 0; i < 8; i++) step(0, 32'h0, 1, 32'h0, 1);
        chk("sat_pht", 32'(dut.pht_reg[10'h3FF]), 3);
        chk("sat_ghr", 32'(dut.ghr_reg), 32'h3FF);
        step(1, 32'h0, 0, 32'h0, 0);
        chk("sat_pred", 32'(bus.prediction), 1);
        step(0, 32'h0, 1, 32'h0, 0);
        chk("desat_pht", 32'(dut.pht_reg[10'h3FF]), 2);
        chk("desat_ghr", 32'(dut.ghr_reg), 32'h3FE);
        // Field 1 ^ 0x3FE = 0x3FF
        step(1, 32'h4, 0, 32'h0, 0);
        chk("desat_pred", 32'(bus.prediction), 1);

        // Same-index predict+update: index 0x3FE holds 01, reality=1
        step(1, 32'h0, 1, 32'h0, 1);
        chk("rw_pred", 32'(bus.prediction), 32'(exp_bypass));
        chk("rw_pht", 32'(dut.pht_reg[10'h3FE]), 2);
        chk("rw_ghr", 32'(dut.ghr_reg), 32'h3FD);

        // Field 3 ^ 0x3FD = 0x3FE -> 10
        step(1, 32'hC, 0, 32'h0, 0);
        chk("pre_rst_pred", 32'(bus.prediction), 1);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pred", 32'(bus.prediction), 0);
        chk("arst_ghr", 32'(dut.ghr_reg), 0);
        chk("arst_pht3fe", 32'(dut.pht_reg[10'h3FE]), 1);
        chk("arst_pht3ff", 32'(dut.pht_reg[10'h3FF]), 1);
        chk("arst_pht0", 32'(dut.pht_reg[0]), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 32'h0, 1);
        chk("post_rst_hold", 32'(bus.prediction), 0);
        chk("post_rst_ghr", 32'(dut.ghr_reg), 0);
        step(1, 32'hC, 0, 32'h0, 0);
        chk("post_rst_pred", 32'(bus.prediction), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/g_share.md
G_SHARE -- requirements
Module: g_share

Interface
REQ-001 Parameter GHR_BITS, default 10, global history length and PHT index width; PHT depth SHALL be 2**GHR_BITS.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 predictPc  input  32  PC of the branch to predict.
REQ-005 updatePc  input  32  PC of the resolved branch being trained.
REQ-006 predict  input  1  prediction request strobe.
REQ-007 update  input  1  training request strobe.
REQ-008 reality  input  1  resolved outcome of updatePc branch; 1 = taken.
REQ-009 prediction  output  1  registered prediction; 1 = taken.

Function
REQ-010 State SHALL be one GHR_BITS-bit global history register (GHR) and a PHT of 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-011 Predict index SHALL be predictPc[GHR_BITS+1:2] XOR GHR; update index SHALL be updatePc[GHR_BITS+1:2] XOR GHR; PC bits [1:0] and above GHR_BITS+1 SHALL be ignored.
REQ-012 On a clock edge with predict=1, prediction SHALL load the MSB of the counter at the predict index; latency one cycle.
REQ-013 With predict=0, prediction SHALL hold its previous value.
REQ-014 On a clock edge with update=1, the counter at the update index SHALL increment if reality=1 and decrement if reality=0, saturating at 11 and 00.
REQ-015 On the same edge, GHR SHALL shift left by one with reality entering bit 0; the MSB is discarded.
REQ-016 With update=0, PHT and GHR SHALL be unchanged; reality is don't-care.
REQ-017 predict and update asserted together: prediction SHALL use the pre-edge GHR and pre-edge counter values (read-before-write), unless REQ-021 applies.
REQ-018 Any number of consecutive update cycles SHALL be accepted, one per cycle; there is no handshake and no stall.

Reset
REQ-019 While rst_n=0: GHR SHALL be 0, every PHT counter SHALL be 01 (weak-NT), prediction SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL discard all training immediately; the first edge after deassertion SHALL behave as from power-up.

Configuration
REQ-021 Macro GSHARE_BYPASS_EN defined: if predict and update are asserted together and the two indices are equal, prediction SHALL take the MSB of the newly computed counter value. Undefined: REQ-017 read-before-write applies in all cases.

Structure
REQ-022 Shared package g_share_pkg SHALL hold the counter-state constants (SNT, WNT, WT, ST) and the 2-bit counter typedef.
REQ-023 Saturating counter next-state logic SHALL be one sub-module, sat_counter2 (inputs: state, taken; output: next state).
REQ-024 PHT SHALL be flop-based so reset clears every entry asynchronously in one step.

Verification
REQ-025 Reset, then predict=1 with predictPc=0 -> prediction=0 (counter[0]=01).
REQ-026 From reset, update=1, updatePc=0, reality=0 -> counter[0]=00, GHR=0; then predict with predictPc=0 -> prediction=0.
REQ-027 From REQ-026 state, three update cycles with updatePc=0, reality=1 -> counter[0]=01, counter[1]=10, counter[3]=10, GHR=0b111; predictPc=0x1C (index 7^7=0) -> prediction=0; predictPc=0x8 (index 2^7=5) -> prediction=0.
REQ-028 Saturation: with GHR held constant via its input pattern, eight taken updates to one index -> counter 11; one not-taken update -> 10 and prediction remains 1.
REQ-029 Simultaneous predict and update to the same index (counter 01, reality=1) -> prediction=0 without GSHARE_BYPASS_EN, 1 with it.
REQ-030 Assert rst_n=0 asynchronously between edges after training -> prediction=0, GHR=0, all counters 01 immediately; predict=0 for several cycles -> prediction holds.
